mips_cpu_bus: RTL and testbench
===============================

Name: mips_cpu_bus

Overview:
- Multi-cycle, non-pipelined MIPS32 (little-endian subset) CPU core with a single Avalon-MM-style memory master port shared by instruction fetch and data access.
- Executes from reset vector 0xBFC00000 until it jumps to address 0, then halts and drops `active`.
- Exposes `$v0` (`$2`) for test observation.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- active  output  1  high while the CPU is running; low once halted.
- register_v0  output  32  current contents of GPR `$2`.
- address  output  32  byte address of the bus transfer; always word-aligned (bits[1:0]=0).
- write  output  1  write request.
- read  output  1  read request.
- waitrequest  input  1  slave stall; a transfer completes on a rising edge where it is low.
- writedata  output  32  store data, lane-aligned.
- byteenable  output  4  active byte lanes (bit0 = addr+0).
- readdata  input  32  read data, sampled on the completing edge.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset, sampled on a clk edge, sets:
  - PC=RESET_VECTOR, next-PC=RESET_VECTOR+4.
  - GPRs, HI and LO = 0.
  - state=FETCH, active=1.
- Outputs while reset is high: read=0, write=0, byteenable=0. A mid-transfer reset abandons the transfer.
- States:
  - FETCH: read=1, address=PC, byteenable=4'b1111. On !waitrequest, latch readdata into IR and go to EXEC.
  - EXEC: decode, run the ALU, update PC. Non-memory instructions write rd/rt (if nonzero) and return to FETCH, so they take 2 cycles with zero waits. Loads and stores go to MEM.
  - MEM: asserts read or write with address = effective address & ~3.
    - On !waitrequest, a load writes rt from readdata.
    - Then go to FETCH.
  - HALT: entered instead of FETCH when the fetch PC is 0. In HALT, active=0 and read=write=0 until reset.
- While waitrequest is high, address, read, write, byteenable and writedata stay stable.
- read and write are never asserted together.
- Branch delay slot: branches and jumps set next-PC. The following instruction always executes before control transfers.
- Effective address = rs + signext(imm16).
- Stores:
  - SW: byteenable 1111.
  - SH: byteenable 0011 if ea[1]=0, else 1100; writedata = {rt[15:0], rt[15:0]}.
  - SB: byteenable = 1 << ea[1:0]; writedata = rt[7:0] replicated across all four lanes.
  - Misaligned SW/SH: the low address bits are ignored.
- Loads: LW only, byteenable 1111.
- Instruction set:
  - Memory: LW, SW, SH, SB.
  - Immediate ALU: ADDIU, ANDI, ORI, XORI (zero-extended immediate), SLTI, SLTIU (sign-extended immediate, unsigned compare for SLTIU), LUI.
  - Register ALU: ADDU, SUBU, AND, OR, XOR, SLT, SLTU.
  - Shifts: SLL, SRL, SRA (shamt); SLLV, SRLV, SRAV (shift amount = rs[4:0], shifting rt).
  - Multiply and HI/LO: MULT (signed) and MULTU (unsigned) write the 64-bit product to {HI,LO}; MFHI, MFLO, MTHI, MTLO.
  - Control: BEQ, BNE (target = PC+4 + signext(imm)<<2); J (target = {PC+4[31:28], idx, 2'b00}); JR.
- No overflow exceptions.
- Unrecognized opcodes execute as NOP.
- `$0` always reads as 0; writes to it are discarded.
- register_v0 is combinational from the `$2` register and updates the cycle after the write.

Test Plan:
- Reset then release, waitrequest=0 → first cycle: read=1, address=0xBFC00000, byteenable=1111, active=1, write=0.
- Run LW $2,0x64($0) with mem[0x64]=123, then SW $2,0xC8($0) → register_v0=123; write cycle with address 0xC8, writedata 123, byteenable 1111.
- LW 3 and 4 into $1/$2; MULT; MFLO $3; SW → stored value 12. With $1=-1 and $2=2:
  - MULT → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- Store tests with $1=9:
  - SB $1,0xCE($0) → address 0xCC, byteenable 0100, writedata 0x09090909.
  - SH $1,0xCE($0) → byteenable 1100, writedata 0x00090009.
- Hold waitrequest=1 for 3 cycles during a fetch and a store → address, read/write, writedata and byteenable unchanged; the instruction completes one cycle after the release.
- JR $0 followed by ADDIU $2,$0,5 in the delay slot → register_v0=5, then active=0, and no further read or write is issued.

Source files
------------

// File: rtl/mips_cpu_bus.sv
// rtl/mips_cpu_bus.sv - multi-cycle MIPS32 subset core with one shared memory master port
// Sequence: FETCH -> EXEC -> (MEM) -> FETCH; execution stops once control reaches address 0.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state;
  logic [31:0] pc, npc, ir, hi, lo, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, imm_se, imm_ze, ea, pc_plus4;
  logic [63:0] mult_s, mult_u;
  logic        is_store;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign imm_se   = {{16{ir[15]}}, ir[15:0]};
  assign imm_ze   = {16'h0000, ir[15:0]};
  assign ea       = rs_val + imm_se;
  assign pc_plus4 = pc + 32'd4;
  assign is_store = (ir[31:29] == 3'b101);
  assign mult_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign mult_u   = {32'h0, rs_val} * {32'h0, rt_val};

  logic        wb_en, br_taken, is_mem;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val, new_hi, new_lo, br_target, st_data;
  logic [3:0]  st_be;

  always_comb begin
    wb_en     = 1'b0;
    wb_idx    = rd;
    wb_val    = '0;
    new_hi    = hi;
    new_lo    = lo;
    br_taken  = 1'b0;
    br_target = pc_plus4 + {imm_se[29:0], 2'b00};
    is_mem    = 1'b0;
    case (opcode)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h00: wb_val = rt_val << shamt;
          6'h02: wb_val = rt_val >> shamt;
          6'h03: wb_val = $signed(rt_val) >>> shamt;
          6'h04: wb_val = rt_val << rs_val[4:0];
          6'h06: wb_val = rt_val >> rs_val[4:0];
          6'h07: wb_val = $signed(rt_val) >>> rs_val[4:0];
          6'h10: wb_val = hi;
          6'h12: wb_val = lo;
          6'h21: wb_val = rs_val + rt_val;
          6'h23: wb_val = rs_val - rt_val;
          6'h24: wb_val = rs_val & rt_val;
          6'h25: wb_val = rs_val | rt_val;
          6'h26: wb_val = rs_val ^ rt_val;
          6'h2A: wb_val = {31'b0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wb_val = {31'b0, rs_val < rt_val};
          default: begin
            wb_en = 1'b0;
            case (funct)
              6'h08: begin br_taken = 1'b1; br_target = rs_val; end
              6'h11: new_hi = rs_val;
              6'h13: new_lo = rs_val;
              6'h18: {new_hi, new_lo} = mult_s;
              6'h19: {new_hi, new_lo} = mult_u;
              default: ;
            endcase
          end
        endcase
      end
      6'h02: begin br_taken = 1'b1; br_target = {pc_plus4[31:28], ir[25:0], 2'b00}; end
      6'h04: br_taken = (rs_val == rt_val);
      6'h05: br_taken = (rs_val != rt_val);
      6'h09: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val + imm_se; end
      6'h0A: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'b0, $signed(rs_val) < $signed(imm_se)}; end
      6'h0B: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'b0, rs_val < imm_se}; end
      6'h0C: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val & imm_ze; end
      6'h0D: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val | imm_ze; end
      6'h0E: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val ^ imm_ze; end
      6'h0F: begin wb_en = 1'b1; wb_idx = rt; wb_val = {ir[15:0], 16'h0000}; end
      6'h23, 6'h28, 6'h29, 6'h2B: is_mem = 1'b1;
      default: ;
    endcase
  end

  // Narrow stores replicate data across lanes so byteenable alone selects the target bytes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = rt_val;
    if (opcode == 6'h29) begin
      st_be   = ea[1] ? 4'b1100 : 4'b0011;
      st_data = {2{rt_val[15:0]}};
    end else if (opcode == 6'h28) begin
      st_be   = 4'b0001 << ea[1:0];
      st_data = {4{rt_val[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      npc       <= RESET_VECTOR + 32'd4;
      ir        <= '0;
      hi        <= '0;
      lo        <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (!waitrequest) begin
          ir    <= readdata;
          state <= EXEC;
        end
        EXEC: begin
          pc  <= npc;
          npc <= br_taken ? br_target : npc + 32'd4;
          hi  <= new_hi;
          lo  <= new_lo;
          if (wb_en && wb_idx != 5'd0) regs[wb_idx] <= wb_val;
          if (is_mem) begin
            mem_addr  <= {ea[31:2], 2'b00};
            mem_be    <= st_be;
            mem_wdata <= st_data;
            state     <= MEM;
          end else begin
            state <= (npc == 32'd0) ? HALT : FETCH;
          end
        end
        MEM: if (!waitrequest) begin
          if (!is_store && rt != 5'd0) regs[rt] <= readdata;
          state <= (pc == 32'd0) ? HALT : FETCH;
        end
        default: ;
      endcase
    end
  end

  assign active      = (state != HALT);
  assign register_v0 = regs[2];
  assign address     = (state == FETCH) ? pc : mem_addr;
  assign read        = !reset && ((state == FETCH) || (state == MEM && !is_store));
  assign write       = !reset && (state == MEM) && is_store;
  assign writedata   = mem_wdata;
  assign byteenable  = reset ? 4'b0000 :
                       (state == FETCH) ? 4'b1111 :
                       (state == MEM) ? mem_be : 4'b0000;
endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb/tb_mips_cpu_bus.sv - directed self-checking bench for mips_cpu_bus
module tb_mips_cpu_bus;
  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] last_addr, last_data;
  logic [3:0]  last_be;
  int          store_count = 0;
  int          overlap = 0;
  int          halt_bus = 0;

  localparam logic [31:0] JR0 = 32'h0000_0008;
  localparam logic [31:0] NOP = 32'h0000_0000;

  mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  assign readdata = (address[31:28] == 4'hB) ? imem[address[9:2]] : dmem[address[9:2]];

  always @(posedge clk) begin
    if (!reset && write && !waitrequest) begin
      last_addr   <= address;
      last_data   <= writedata;
      last_be     <= byteenable;
      store_count <= store_count + 1;
    end
    if (!reset && read && write) overlap <= overlap + 1;
    if (!reset && !active && (read || write)) halt_bus <= halt_bus + 1;
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic load(input logic [31:0] prog [$]);
    for (int i = 0; i < 256; i++) imem[i] = NOP;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
  endtask

  task automatic run_prog(input string name);
    int n;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (active && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL %s_halt: active=%b after %0d cycles, required 0", name, active, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    load('{JR0, NOP});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read, write, byteenable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_bus: read=%b write=%b be=%b, required 0 0 0000", read, write, byteenable);
    end
    checks++;
    if ({active, register_v0} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: active=%b v0=%h, required 1 00000000", active, register_v0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({read, write, address, byteenable, active} !== {1'b1, 1'b0, 32'hBFC00000, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL first_fetch: read=%b write=%b addr=%h be=%b active=%b, required 1 0 bfc00000 1111 1",
               read, write, address, byteenable, active);
    end
  endtask

  task automatic test_lw_sw();
    int c0;
    dmem[32'h64 >> 2] = 32'd123;
    load('{itype(6'h23, 0, 2, 16'h0064), itype(6'h2B, 0, 2, 16'h00C8), JR0, NOP});
    c0 = store_count;
    run_prog("lw_sw");
    checks++;
    if (register_v0 !== 32'd123) begin
      errors++;
      $display("FAIL lw_v0: got %h, required 0000007b", register_v0);
    end
    checks++;
    if ({last_addr, last_data, last_be} !== {32'hC8, 32'd123, 4'b1111} || store_count - c0 != 1) begin
      errors++;
      $display("FAIL sw_bus: addr=%h data=%h be=%b stores=%0d, required c8 7b 1111 1",
               last_addr, last_data, last_be, store_count - c0);
    end
  endtask

  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] fn, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    dmem[4] = a;
    dmem[5] = b;
    load('{itype(6'h23, 0, 1, 16'h0010), itype(6'h23, 0, 2, 16'h0014), rtype(1, 2, 0, 0, fn),
           rtype(0, 0, 3, 0, 6'h12), itype(6'h2B, 0, 3, 16'h00C8), rtype(0, 0, 2, 0, 6'h10), JR0, NOP});
    run_prog(name);
    checks++;
    if (last_data !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h, required %h", name, last_data, exp_lo);
    end
    checks++;
    if (register_v0 !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h, required %h", name, register_v0, exp_hi);
    end
  endtask

  task automatic test_mult();
    run_mult("mult_3x4", 32'd3, 32'd4, 6'h18, 32'h0, 32'd12);
    run_mult("mult_neg", 32'hFFFFFFFF, 32'd2, 6'h18, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mult("multu_neg", 32'hFFFFFFFF, 32'd2, 6'h19, 32'h00000001, 32'hFFFFFFFE);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_vec_t;

  task automatic test_store_lanes();
    st_vec_t v [5];
    int c0;
    v[0] = '{"sb_ce", itype(6'h28, 0, 1, 16'h00CE), 32'hCC, 4'b0100, 32'h09090909};
    v[1] = '{"sh_ce", itype(6'h29, 0, 1, 16'h00CE), 32'hCC, 4'b1100, 32'h00090009};
    v[2] = '{"sh_cc", itype(6'h29, 0, 1, 16'h00CC), 32'hCC, 4'b0011, 32'h00090009};
    v[3] = '{"sb_c9", itype(6'h28, 0, 1, 16'h00C9), 32'hC8, 4'b0010, 32'h09090909};
    v[4] = '{"sw_ca", itype(6'h2B, 0, 1, 16'h00CA), 32'hC8, 4'b1111, 32'h00000009};
    foreach (v[i]) begin
      load('{itype(6'h09, 0, 1, 16'h0009), v[i].instr, JR0, NOP});
      c0 = store_count;
      run_prog(v[i].name);
      checks++;
      if ({last_addr, last_be, last_data} !== {v[i].addr, v[i].be, v[i].data} || store_count - c0 != 1) begin
        errors++;
        $display("FAIL %s: addr=%h be=%b data=%h stores=%0d, required %h %b %h 1", v[i].name,
                 last_addr, last_be, last_data, store_count - c0, v[i].addr, v[i].be, v[i].data);
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v [22];
    v[0]  = '{"addu",  rtype(4, 5, 2, 0, 6'h21), NOP, 32'hFFFFFFFC};
    v[1]  = '{"subu",  rtype(5, 4, 2, 0, 6'h23), NOP, 32'h0000000A};
    v[2]  = '{"slt",   rtype(4, 5, 2, 0, 6'h2A), NOP, 32'h00000001};
    v[3]  = '{"sltu",  rtype(4, 5, 2, 0, 6'h2B), NOP, 32'h00000000};
    v[4]  = '{"and",   rtype(4, 5, 2, 0, 6'h24), NOP, 32'h00000001};
    v[5]  = '{"or",    rtype(4, 5, 2, 0, 6'h25), NOP, 32'hFFFFFFFB};
    v[6]  = '{"xor",   rtype(4, 5, 2, 0, 6'h26), NOP, 32'hFFFFFFFA};
    v[7]  = '{"sll",   rtype(0, 5, 2, 4, 6'h00), NOP, 32'h00000030};
    v[8]  = '{"sra",   rtype(0, 4, 2, 1, 6'h03), NOP, 32'hFFFFFFFC};
    v[9]  = '{"srl",   rtype(0, 4, 2, 28, 6'h02), NOP, 32'h0000000F};
    v[10] = '{"sllv",  rtype(5, 4, 2, 0, 6'h04), NOP, 32'hFFFFFFC8};
    v[11] = '{"srlv",  rtype(5, 4, 2, 0, 6'h06), NOP, 32'h1FFFFFFF};
    v[12] = '{"srav",  rtype(5, 4, 2, 0, 6'h07), NOP, 32'hFFFFFFFF};
    v[13] = '{"xori",  itype(6'h0E, 4, 2, 16'hFFFF), NOP, 32'hFFFF0006};
    v[14] = '{"andi",  itype(6'h0C, 4, 2, 16'h00F0), NOP, 32'h000000F0};
    v[15] = '{"ori",   itype(6'h0D, 5, 2, 16'h8000), NOP, 32'h00008003};
    v[16] = '{"lui",   itype(6'h0F, 0, 2, 16'h1234), NOP, 32'h12340000};
    v[17] = '{"slti",  itype(6'h0A, 4, 2, 16'hFFF8), NOP, 32'h00000000};
    v[18] = '{"sltiu", itype(6'h0B, 5, 2, 16'hFFFF), NOP, 32'h00000001};
    v[19] = '{"mthi",  rtype(4, 0, 0, 0, 6'h11), rtype(0, 0, 2, 0, 6'h10), 32'hFFFFFFF9};
    v[20] = '{"zero_reg", itype(6'h09, 0, 0, 16'h0005), rtype(0, 5, 2, 0, 6'h21), 32'h00000003};
    v[21] = '{"bad_op", itype(6'h3F, 0, 2, 16'hFFFF), NOP, 32'h00000000};
    foreach (v[i]) begin
      load('{itype(6'h09, 0, 4, 16'hFFF9), itype(6'h09, 0, 5, 16'h0003), v[i].i1, v[i].i2, JR0, NOP});
      run_prog(v[i].name);
      checks++;
      if (register_v0 !== v[i].exp) begin
        errors++;
        $display("FAIL %s: v0=%h, required %h", v[i].name, register_v0, v[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] tgt;
    logic [31:0] ctl [3];
    logic [31:0] exp [3];
    string       nm [3];
    tgt = 32'hBFC00010;
    ctl[0] = itype(6'h04, 0, 0, 16'h0002); exp[0] = 32'd11; nm[0] = "beq_taken";
    ctl[1] = itype(6'h05, 0, 0, 16'h0002); exp[1] = 32'd15; nm[1] = "bne_not_taken";
    ctl[2] = {6'h02, tgt[27:2]};           exp[2] = 32'd11; nm[2] = "j_delay";
    for (int i = 0; i < 3; i++) begin
      load('{itype(6'h09, 0, 2, 16'h0001), ctl[i], itype(6'h09, 2, 2, 16'h0002),
             itype(6'h09, 2, 2, 16'h0004), itype(6'h09, 2, 2, 16'h0008), JR0, NOP});
      run_prog(nm[i]);
      checks++;
      if (register_v0 !== exp[i]) begin
        errors++;
        $display("FAIL %s: v0=%0d, required %0d", nm[i], register_v0, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back_wait();
    logic [69:0] snap;
    int n, c0;
    dmem[32'h64 >> 2] = 32'd123;
    load('{itype(6'h23, 0, 2, 16'h0064), itype(6'h2B, 0, 2, 16'h00C8), JR0, NOP});
    c0 = store_count;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b1;
    #1;
    snap = {address, writedata, read, write, byteenable};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({address, writedata, read, write, byteenable} !== snap) begin
        errors++;
        $display("FAIL fetch_stall_%0d: bus=%h, required %h", k, {address, writedata, read, write, byteenable}, snap);
      end
    end
    waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_release: read=%b one cycle after release, required 0", read);
    end
    n = 0;
    while (write !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    waitrequest = 1'b1;
    #1;
    snap = {address, writedata, read, write, byteenable};
    checks++;
    if (snap !== {32'hC8, 32'd123, 1'b0, 1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL store_request: bus=%h, required %h", snap, {32'hC8, 32'd123, 1'b0, 1'b1, 4'b1111});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({address, writedata, read, write, byteenable} !== snap || store_count != c0) begin
        errors++;
        $display("FAIL store_stall_%0d: bus=%h stores=%0d, required %h 0", k,
                 {address, writedata, read, write, byteenable}, store_count - c0, snap);
      end
    end
    waitrequest = 1'b0;
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || store_count - c0 != 1) begin
      errors++;
      $display("FAIL store_release: write=%b stores=%0d, required 0 1", write, store_count - c0);
    end
  endtask

  task automatic test_halt();
    load('{JR0, itype(6'h09, 0, 2, 16'h0005)});
    run_prog("halt");
    checks++;
    if (register_v0 !== 32'd5) begin
      errors++;
      $display("FAIL halt_delay_slot: v0=%h, required 00000005", register_v0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (halt_bus != 0 || read !== 1'b0 || write !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL halt_quiet: accesses=%0d read=%b write=%b active=%b, required 0 0 0 0",
               halt_bus, read, write, active);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({active, register_v0} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL halt_reset: active=%b v0=%h, required 1 00000000", active, register_v0);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL rw_exclusive: %0d cycles with read and write, required 0", overlap);
    end
  endtask

  initial begin
    reset = 1'b1;
    waitrequest = 1'b0;
    test_reset();
    test_lw_sw();
    test_mult();
    test_store_lanes();
    test_alu();
    test_branch();
    test_back_to_back_wait();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
